hs32_lsu_gen: RTL

Parametrised AHB-lite load/store unit for the hs32 memory stage. Successor to the fixed word-only LSU. Adds:
- configurable data-bus width;
- byte, halfword and word (and doubleword at DW=64) accesses, with lane steering and sign or zero extension;
- misalignment detection;
- AHB two-cycle ERROR response handling, with a latched fault that the trap logic clears.

It sits between the execute stage and the AHB-lite data bus, and drives the regfile write port and the hazard/forwarding network.

---
 rtl/hs32_lsu_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/hs32_lsu_gen.sv
// hs32_lsu_gen: parametrised AHB-lite load/store unit for the hs32 memory stage.
// Two registered stages (address, data) with lane steering, extension and fault trapping.
//
// state | meaning
// RUN   | issuing ops, both stages advance whenever HREADY_i is high
// ERR   | bus ERROR seen in data phase, waiting for its second cycle
// HALT  | fault latched, bus idle, waiting for clear_i
module hs32_lsu_gen #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [RW-1:0] rd_i,
    input  logic          regwe_i,
    input  logic          memwe_i,
    input  logic [1:0]    size_i,
    input  logic          sext_i,
    input  logic          clear_i,
    output logic [RW+1:0] l1_o,
    output logic [RW+1:0] l2_o,
    output logic [DW-1:0] fwd_o,
    output logic [RW-1:0] wp_addr_o,
    output logic [DW-1:0] wp_data_o,
    output logic          wp_we_o,
    output logic          fault_o,
    output logic [1:0]    fault_cause_o,
    output logic [AW-1:0] fault_addr_o,
    input  logic          HREADY_i,
    input  logic          HRESP_i,
    input  logic [DW-1:0] HRDATA_i,
    output logic [AW-1:0] HADDR_o,
    output logic          HWRITE_o,
    output logic [2:0]    HSIZE_o,
    output logic [2:0]    HBURST_o,
    output logic [3:0]    HPROT_o,
    output logic [1:0]    HTRANS_o,
    output logic          HMASTLOCK_o,
    output logic [DW-1:0] HWDATA_o
);

    localparam int LB = $clog2(DW / 8);
    localparam bit HAS_DW64 = (DW == 64);

    typedef enum logic [1:0] {RUN, ERR, HALT} state_t;

    state_t        state;

    logic          a_valid, a_hwrite, a_regwe, a_sext;
    logic [AW-1:0] a_haddr;
    logic [1:0]    a_hsize;
    logic [RW-1:0] a_rd;
    logic [DW-1:0] a_wdata;

    logic          d_valid, d_hwrite, d_regwe, d_sext;
    logic [AW-1:0] d_haddr;
    logic [1:0]    d_hsize;
    logic [RW-1:0] d_rd;
    logic [DW-1:0] d_wdata;

    logic          advance, accept, issue, illegal, misal, bad_op;
    logic          d_ok, sign_bit;
    logic [LB-1:0] d_off;
    logic [DW-1:0] lane, load_data;

    assign advance = HREADY_i && (state == RUN);
    // A latched misaligned/illegal fault blocks new ops while stage D drains.
    assign ready_o = advance && !fault_o;
    assign accept  = valid_i && ready_o;
    assign issue   = accept && !bad_op;

    always_comb begin
        illegal = (size_i == 2'd3) && !HAS_DW64;
        case (size_i)
            2'd1:    misal = addr_i[0];
            2'd2:    misal = |addr_i[1:0];
            2'd3:    misal = |addr_i[2:0];
            default: misal = 1'b0;
        endcase
        bad_op = illegal || misal;
    end

    assign d_off = d_haddr[LB-1:0];
    assign lane  = HRDATA_i >> {d_off, 3'b000};

    always_comb begin
        case (d_hsize)
            2'd0:    sign_bit = lane[7];
            2'd1:    sign_bit = lane[15];
            2'd2:    sign_bit = lane[31];
            default: sign_bit = lane[DW-1];
        endcase
        for (int i = 0; i < DW; i++) begin
            load_data[i] = (i < (8 << d_hsize)) ? lane[i] : (sign_bit & d_sext);
        end
    end

    always_comb begin
        case (d_hsize)
            2'd0:    HWDATA_o = {(DW / 8){d_wdata[7:0]}};
            2'd1:    HWDATA_o = {(DW / 16){d_wdata[15:0]}};
            2'd2:    HWDATA_o = {(DW / 32){d_wdata[31:0]}};
            default: HWDATA_o = d_wdata;
        endcase
    end

    assign d_ok      = d_valid && HREADY_i && !HRESP_i;
    assign wp_we_o   = d_ok && d_regwe;
    assign wp_addr_o = d_rd;
    assign wp_data_o = load_data;
    assign fwd_o     = load_data;
    assign l1_o      = {a_rd, a_valid && a_regwe, a_regwe};
    assign l2_o      = {d_rd, d_ok && d_regwe, d_regwe};

    assign HADDR_o     = a_haddr;
    assign HWRITE_o    = a_hwrite;
    assign HSIZE_o     = {1'b0, a_hsize};
    assign HTRANS_o    = a_valid ? 2'b10 : 2'b00;
    assign HBURST_o    = 3'b000;
    assign HPROT_o     = 4'b0011;
    assign HMASTLOCK_o = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            a_valid       <= 1'b0;
            a_hwrite      <= 1'b0;
            a_regwe       <= 1'b0;
            a_sext        <= 1'b0;
            a_haddr       <= '0;
            a_hsize       <= 2'd2;
            a_rd          <= '0;
            a_wdata       <= '0;
            d_valid       <= 1'b0;
            d_hwrite      <= 1'b0;
            d_regwe       <= 1'b0;
            d_sext        <= 1'b0;
            d_haddr       <= '0;
            d_hsize       <= 2'd2;
            d_rd          <= '0;
            d_wdata       <= '0;
            fault_o       <= 1'b0;
            fault_cause_o <= 2'd0;
            fault_addr_o  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (d_valid && HRESP_i && !HREADY_i) begin
                        state   <= ERR;
                        a_valid <= 1'b0;
                    end else begin
                        if (HREADY_i) begin
                            d_valid  <= a_valid;
                            d_hwrite <= a_hwrite;
                            d_regwe  <= a_regwe;
                            d_sext   <= a_sext;
                            d_haddr  <= a_haddr;
                            d_hsize  <= a_hsize;
                            d_rd     <= a_rd;
                            d_wdata  <= a_wdata;
                            a_valid  <= issue;
                            if (issue) begin
                                a_hwrite <= memwe_i;
                                a_regwe  <= regwe_i;
                                a_sext   <= sext_i;
                                a_haddr  <= addr_i;
                                a_hsize  <= size_i;
                                a_rd     <= rd_i;
                                a_wdata  <= wdata_i;
                            end
                            if (accept && bad_op) begin
                                fault_o       <= 1'b1;
                                fault_cause_o <= illegal ? 2'd3 : 2'd1;
                                fault_addr_o  <= addr_i;
                            end
                        end
                        // Stage A is already empty here; halt once D has retired.
                        if (fault_o && (HREADY_i || !d_valid)) state <= HALT;
                    end
                end
                ERR: begin
                    if (HREADY_i) begin
                        state         <= HALT;
                        d_valid       <= 1'b0;
                        fault_o       <= 1'b1;
                        fault_cause_o <= 2'd2;
                        fault_addr_o  <= d_haddr;
                    end
                end
                HALT: begin
                    if (clear_i) begin
                        state         <= RUN;
                        fault_o       <= 1'b0;
                        fault_cause_o <= 2'd0;
                        fault_addr_o  <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
